// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, ALU control codes and
// register-address width used by the decode stage and the register file.
package mips_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_e;

endpackage

// File: rtl/etapa_id_banco_registros.sv
// 32x32 register file: two async read ports with write-through bypass,
// one sync write port, $0 hardwired to zero, async active-low reset.
module banco_registros
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // A write landing this cycle is visible to a read of the same register.
  always_comb begin
    o_rd1 = r_mem[i_ra1];
    o_rd2 = r_mem[i_ra2];
    if (i_ra1 == '0)                   o_rd1 = '0;
    else if (i_we && (i_wa == i_ra1))  o_rd1 = i_wd;
    if (i_ra2 == '0)                   o_rd2 = '0;
    else if (i_we && (i_wa == i_ra2))  o_rd2 = i_wd;
  end

endmodule

// File: rtl/etapa_id.sv
// MIPS instruction-decode stage with ID/EX register and register file.
// Macro ETAPA_ID_HAZARD_EN enables load-use stall/bubble insertion.
module etapa_id
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] In,
  output logic [DATA_W-1:0] PC,
  output logic [REG_AW-1:0] Reg_RD,
  output logic [REG_AW-1:0] Reg_RT,
  output logic [DATA_W-1:0] Dato_1,
  output logic [DATA_W-1:0] Dato_2,
  output logic              ALUsrc,
  output logic [3:0]        ALUcontrol,
  output logic              Regdst,
  output logic              ALU_enable,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              illegal
);

  logic [5:0]        w_op, w_fn;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_ext;
  alu_e              w_alu;
  logic              w_legal, w_alusrc, w_regdst, w_wr, w_mr, w_mw, w_br;
  logic              w_advance, w_hazard;

  assign w_op  = instr_in[31:26];
  assign w_rs  = instr_in[25:21];
  assign w_rt  = instr_in[20:16];
  assign w_rd  = instr_in[15:11];
  assign w_fn  = instr_in[5:0];
  assign w_imm = instr_in[15:0];

  banco_registros #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (wb_en),
    .i_wa  (wb_addr),
    .i_wd  (wb_data)
  );

  always_comb begin
    w_legal  = 1'b1;
    w_alu    = ALU_ADD;
    w_alusrc = 1'b1;
    w_regdst = 1'b0;
    w_wr     = 1'b1;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_br     = 1'b0;
    w_ext    = {{(DATA_W-16){w_imm[15]}}, w_imm};
    case (w_op)
      OP_RTYPE: begin
        w_alusrc = 1'b0;
        w_regdst = 1'b1;
        w_ext    = '0;
        case (w_fn)
          FN_ADD:  w_alu = ALU_ADD;
          FN_SUB:  w_alu = ALU_SUB;
          FN_AND:  w_alu = ALU_AND;
          FN_OR:   w_alu = ALU_OR;
          FN_NOR:  w_alu = ALU_NOR;
          FN_SLT:  w_alu = ALU_SLT;
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI: w_alu = ALU_ADD;
      OP_SLTI: w_alu = ALU_SLT;
      OP_ANDI: begin
        w_alu = ALU_AND;
        w_ext = {{(DATA_W-16){1'b0}}, w_imm};
      end
      OP_ORI: begin
        w_alu = ALU_OR;
        w_ext = {{(DATA_W-16){1'b0}}, w_imm};
      end
      OP_LW: w_mr = 1'b1;
      OP_SW: begin
        w_mw = 1'b1;
        w_wr = 1'b0;
      end
      OP_BEQ: begin
        w_alusrc = 1'b0;
        w_alu    = ALU_SUB;
        w_br     = 1'b1;
        w_wr     = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_wr = 1'b0;
      w_mr = 1'b0;
      w_mw = 1'b0;
      w_br = 1'b0;
    end
  end

`ifdef ETAPA_ID_HAZARD_EN
  logic w_rt_src;
  assign w_rt_src = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ);
  assign w_hazard = ex_valid && mem_read && (Reg_RT != '0) &&
                    ((Reg_RT == w_rs) || (w_rt_src && (Reg_RT == w_rt)));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_advance = !ex_valid || ex_ready;
  assign if_ready  = w_advance && !w_hazard;

  // Bubbles zero the whole entry so data outputs stay deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0; In <= '0; PC <= '0; Reg_RD <= '0; Reg_RT <= '0;
      Dato_1 <= '0; Dato_2 <= '0; ALUsrc <= 1'b0; ALUcontrol <= '0;
      Regdst <= 1'b0; ALU_enable <= 1'b0; reg_write <= 1'b0;
      mem_read <= 1'b0; mem_write <= 1'b0; branch <= 1'b0; illegal <= 1'b0;
    end else if (w_advance) begin
      if (if_valid && !w_hazard) begin
        ex_valid   <= 1'b1;
        In         <= w_ext;
        PC         <= pc_in + DATA_W'(4);
        Reg_RD     <= w_rd;
        Reg_RT     <= w_rt;
        Dato_1     <= w_rd1;
        Dato_2     <= w_rd2;
        ALUsrc     <= w_alusrc;
        ALUcontrol <= w_alu;
        Regdst     <= w_regdst;
        ALU_enable <= w_legal;
        reg_write  <= w_wr;
        mem_read   <= w_mr;
        mem_write  <= w_mw;
        branch     <= w_br;
        illegal    <= !w_legal;
      end else begin
        ex_valid <= 1'b0; In <= '0; PC <= '0; Reg_RD <= '0; Reg_RT <= '0;
        Dato_1 <= '0; Dato_2 <= '0; ALUsrc <= 1'b0; ALUcontrol <= '0;
        Regdst <= 1'b0; ALU_enable <= 1'b0; reg_write <= 1'b0;
        mem_read <= 1'b0; mem_write <= 1'b0; branch <= 1'b0; illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_etapa_id.sv
// Self-checking bench for etapa_id: directed literal checks plus a randomized
// run against a behavioural ID/EX model; honours ETAPA_ID_HAZARD_EN.
module tb_etapa_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in, pc_in, wb_data;
  logic        if_valid, if_ready, wb_en, ex_ready, ex_valid;
  logic [4:0]  wb_addr, Reg_RD, Reg_RT;
  logic [31:0] In, PC, Dato_1, Dato_2;
  logic        ALUsrc, Regdst, ALU_enable, reg_write, mem_read, mem_write, branch, illegal;
  logic [3:0]  ALUcontrol;

  always #5 clk = ~clk;

  etapa_id #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
    .if_valid(if_valid), .if_ready(if_ready), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .In(In), .PC(PC),
    .Reg_RD(Reg_RD), .Reg_RT(Reg_RT), .Dato_1(Dato_1), .Dato_2(Dato_2),
    .ALUsrc(ALUsrc), .ALUcontrol(ALUcontrol), .Regdst(Regdst), .ALU_enable(ALU_enable),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_SLT,
                M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LW, M_SW, M_BEQ} mn_e;

  typedef struct {
    bit        v;
    bit [31:0] imm, pc, d1, d2;
    bit [4:0]  rd, rt;
    bit        alusrc, regdst, alu_en, rw, mr, mw, br, ill;
    bit [3:0]  alu;
  } exp_t;

  exp_t      m;
  bit [31:0] rf [32];

  function automatic mn_e classify(input bit [31:0] ins);
    bit [5:0] op = ins[31:26];
    bit [5:0] fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
        6'h25: return M_OR;   6'h27: return M_NOR;  6'h2A: return M_SLT;
        default: return M_ILL;
      endcase
    end
    case (op)
      6'h08: return M_ADDI; 6'h0A: return M_SLTI; 6'h0C: return M_ANDI;
      6'h0D: return M_ORI;  6'h23: return M_LW;   6'h2B: return M_SW;
      6'h04: return M_BEQ;
      default: return M_ILL;
    endcase
  endfunction

  function automatic bit [31:0] rd_reg(input bit [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return rf[a];
  endfunction

  function automatic exp_t decode(input bit [31:0] ins, input bit [31:0] pc);
    exp_t e;
    mn_e  k  = classify(ins);
    bit [31:0] sx = {{16{ins[15]}}, ins[15:0]};
    bit [31:0] zx = {16'h0, ins[15:0]};
    e = '{default: 0};
    e.v  = 1; e.pc = pc + 32'd4; e.rd = ins[15:11]; e.rt = ins[20:16];
    e.d1 = rd_reg(ins[25:21]); e.d2 = rd_reg(ins[20:16]);
    case (k)
      M_ADD, M_ADDI, M_LW, M_SW: e.alu = 4'b0010;
      M_SUB, M_BEQ:              e.alu = 4'b0110;
      M_AND, M_ANDI:             e.alu = 4'b0000;
      M_OR,  M_ORI:              e.alu = 4'b0001;
      M_NOR:                     e.alu = 4'b1100;
      M_SLT, M_SLTI:             e.alu = 4'b0111;
      default:                   e.alu = 4'b0000;
    endcase
    case (k)
      M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_SLT: begin e.regdst = 1; e.rw = 1; e.imm = 0; end
      M_ADDI, M_SLTI: begin e.alusrc = 1; e.rw = 1; e.imm = sx; end
      M_ANDI, M_ORI:  begin e.alusrc = 1; e.rw = 1; e.imm = zx; end
      M_LW:  begin e.alusrc = 1; e.rw = 1; e.mr = 1; e.imm = sx; end
      M_SW:  begin e.alusrc = 1; e.mw = 1; e.imm = sx; end
      M_BEQ: begin e.br = 1; e.imm = sx; end
      default: e.ill = 1;
    endcase
    e.alu_en = !e.ill;
    return e;
  endfunction

  function automatic bit model_hazard();
`ifdef ETAPA_ID_HAZARD_EN
    bit rt_src = (instr_in[31:26] == 6'h00) || (instr_in[31:26] == 6'h2B) ||
                 (instr_in[31:26] == 6'h04);
    return m.v && m.mr && (m.rt != 0) &&
           ((m.rt == instr_in[25:21]) || (rt_src && m.rt == instr_in[20:16]));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: 0};
      foreach (rf[i]) rf[i] = 32'h0;
    end else begin
      if (!m.v || ex_ready) begin
        if (if_valid && !model_hazard()) m = decode(instr_in, pc_in);
        else                             m = '{default: 0};
      end
      if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_valid",   ex_valid,   m.v);
      chk("if_ready",   if_ready,   (!m.v || ex_ready) && !model_hazard());
      chk("ALU_enable", ALU_enable, m.alu_en);
      chk("reg_write",  reg_write,  m.rw);
      chk("mem_read",   mem_read,   m.mr);
      chk("mem_write",  mem_write,  m.mw);
      chk("branch",     branch,     m.br);
      chk("illegal",    illegal,    m.ill);
      if (m.v) begin
        chk("PC",     PC,     m.pc);
        chk("Reg_RD", Reg_RD, m.rd);
        chk("Reg_RT", Reg_RT, m.rt);
        chk("Dato_1", Dato_1, m.d1);
        chk("Dato_2", Dato_2, m.d2);
        if (!m.ill) begin
          chk("In",         In,         m.imm);
          chk("ALUsrc",     ALUsrc,     m.alusrc);
          chk("ALUcontrol", ALUcontrol, m.alu);
          chk("Regdst",     Regdst,     m.regdst);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                       input bit we, input bit [4:0] wa, input bit [31:0] wd, input bit rdy);
    if_valid = v; instr_in = ins; pc_in = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = rdy;
    @(posedge clk); #1;
  endtask

  function automatic bit [31:0] rnd_instr();
    bit [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    bit [5:0] ops [7] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
    bit [4:0] rs = 5'($urandom_range(0, 7));
    bit [4:0] rt = 5'($urandom_range(0, 7));
    bit [4:0] rd = 5'($urandom_range(0, 7));
    bit [15:0] imm = 16'($urandom);
    int unsigned k = $urandom_range(0, 15);
    if (k < 5)   return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
    if (k < 13)  return {ops[$urandom_range(0, 6)], rs, rt, imm};
    if (k == 13) return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b1;
    if_valid = 0; instr_in = 0; pc_in = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_PC", PC, 0);
    chk("rst_ALU_enable", ALU_enable, 0);

    // 2. add $3,$1,$2
    drive(0, 0, 0, 1, 5'd1, 32'h25, 1);
    drive(0, 0, 0, 1, 5'd2, 32'h35, 1);
    drive(1, 32'h00221820, 32'h4, 0, 0, 0, 1);
    chk("add_Dato_1", Dato_1, 32'h25);
    chk("add_Dato_2", Dato_2, 32'h35);
    chk("add_Reg_RD", Reg_RD, 3);
    chk("add_Regdst", Regdst, 1);
    chk("add_ALUsrc", ALUsrc, 0);
    chk("add_ALUcontrol", ALUcontrol, 4'b0010);
    chk("add_PC", PC, 32'h8);
    chk("add_ALU_enable", ALU_enable, 1);

    // 3. immediates
    drive(1, 32'h2024FFFF, 32'h8, 0, 0, 0, 1);
    chk("addi_In", In, 32'hFFFFFFFF);
    chk("addi_ALUsrc", ALUsrc, 1);
    chk("addi_Regdst", Regdst, 0);
    chk("addi_Reg_RT", Reg_RT, 4);
    drive(1, 32'h3405FFFF, 32'hC, 0, 0, 0, 1);
    chk("ori_In", In, 32'h0000FFFF);
    chk("ori_ALUcontrol", ALUcontrol, 4'b0001);

    // 4. bypass and $0
    drive(1, 32'h00C03820, 32'h10, 1, 5'd6, 32'hDEAD, 1);
    chk("byp_Dato_1", Dato_1, 32'hDEAD);
    chk("byp_Dato_2", Dato_2, 0);
    drive(0, 0, 0, 1, 5'd0, 32'h5, 1);
    drive(1, 32'h00004820, 32'h14, 0, 0, 0, 1);
    chk("r0_Dato_1", Dato_1, 0);
    chk("r0_Dato_2", Dato_2, 0);

    // 5. load-use
    drive(1, 32'h8C270000, 32'h40, 0, 0, 0, 1);
    if_valid = 1; instr_in = 32'h00E14020; pc_in = 32'h44; #1;
`ifdef ETAPA_ID_HAZARD_EN
    chk("lu_if_ready", if_ready, 0);
    @(posedge clk); #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_if_ready2", if_ready, 1);
    drive(1, 32'h00E14020, 32'h44, 0, 0, 0, 1);
`else
    chk("lu_if_ready", if_ready, 1);
    @(posedge clk); #1;
`endif
    chk("lu_ex_valid", ex_valid, 1);
    chk("lu_Reg_RD", Reg_RD, 8);

    // 6. backpressure and illegal
    drive(1, 32'h00221820, 32'h100, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00004820, 32'h200, 0, 0, 0, 0);
      chk("bp_if_ready", if_ready, 0);
      chk("bp_PC", PC, 32'h104);
      chk("bp_Reg_RD", Reg_RD, 3);
    end
    drive(1, 32'hFC000000, 32'h300, 0, 0, 0, 1);
    chk("ill_illegal", illegal, 1);
    chk("ill_ALU_enable", ALU_enable, 0);
    chk("ill_reg_write", reg_write, 0);
    chk("ill_ex_valid", ex_valid, 1);

    // randomized run with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, rnd_instr(), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
